mantissa_normalize_unit: RTL
============================

MANTISSA_NORMALIZE_UNIT -- requirements
Module: mantissa_normalize_unit

Interface
REQ-001 The block SHALL have these ports (no parameters): i_clk  in  1  sole clock, rising edge.
REQ-002 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 i_valid  in  1  upstream holds a valid raw sum.
REQ-004 o_ready  out  1  block accepts the raw sum this cycle.
REQ-005 i_sign  in  1  result sign, passed through unchanged.
REQ-006 i_exp  in  8  effective biased exponent of the larger operand; legal range 1..254.
REQ-007 i_mant  in  25  raw mantissa sum: bit24 carry, bit23 hidden-bit position, bits22:0 fraction.
REQ-008 o_valid  out  1  normalized result valid.
REQ-009 i_ready  in  1  downstream accepts the result.
REQ-010 o_sign  out  1  sign of the result.
REQ-011 o_exp  out  8  normalized biased exponent.
REQ-012 o_fract  out  23  normalized fraction, hidden bit removed.
REQ-013 o_is_subnormal  out  1  result is subnormal (o_exp=0, o_fract non-zero).
REQ-014 o_zero  out  1  result is exactly zero.
REQ-015 o_overflow  out  1  exponent reached 255; result is infinity (o_fract=0).

Function
REQ-016 Two-stage pipeline: S1 registers the inputs plus a leading-zero count lzc (0..23) of i_mant[23:0]. S2 registers the shifted fraction, the exponent and the flags.
REQ-017 Latency SHALL be exactly 2 cycles from the accept edge to o_valid when no stall occurs. Throughput SHALL be 1 result per cycle.
REQ-018 Handshake: a transfer occurs on an edge where valid and ready are both high. o_ready = !S1_valid | S1_advance. S1_advance = !S2_valid | i_ready.
REQ-019 o_valid together with all result outputs SHALL stay stable while o_valid=1 and i_ready=0.
REQ-020 If i_mant=0: o_zero=1, o_exp=0, o_fract=0, and o_is_subnormal=0 and o_overflow=0.
REQ-021 If i_mant[24]=1: the mantissa shifts right by 1 with truncation (the LSB is dropped), and exp = i_exp+1.
REQ-022 If the i_mant[24]=1 case gives exp=255: o_overflow=1, o_exp=255 and o_fract=0.
REQ-023 Else, if i_exp > lzc: shift left by lzc, o_exp = i_exp-lzc, o_is_subnormal=0.
REQ-024 Else, if i_exp <= lzc: shift left by i_exp-1, o_exp=0, o_is_subnormal=1.
REQ-025 o_fract SHALL take bits 22:0 of the shifted mantissa, with zeros filling from the right.
REQ-026 All exponent arithmetic SHALL be done in 9 bits. No wrap-around is permitted.
REQ-027 Exactly one of the following SHALL hold whenever o_valid=1: o_zero=1, o_overflow=1, o_is_subnormal=1, or a normal result (all three flags 0).
REQ-028 Outputs while o_valid=0 are don't-care except o_valid itself.
REQ-029 A stall at S2 SHALL back-pressure S1. S1 SHALL then hold its contents, and o_ready=0 while S1 is full.
REQ-030 Simultaneous S2 drain and S1 refill in the same cycle SHALL lose no data and duplicate no data.

Reset
REQ-031 On i_rst_n=0, immediately and independent of i_clk, the block SHALL clear S1_valid and S2_valid, set o_valid=0, and zero o_sign, o_exp, o_fract and all flags.
REQ-032 o_ready SHALL be 1 while i_rst_n=0 and in the first cycle after release.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight results. No result SHALL appear after release until a new input is accepted.

Verification
REQ-034 Carry case: i_exp=127, i_mant=0x1800000 -> 2 cycles later o_exp=128, o_fract=0x400000, all flags 0.
REQ-035 Cancellation case: i_exp=130, i_mant=0x000010 (lzc=19) -> o_exp=111, o_fract=0x000000, normal.
REQ-036 Subnormal and zero cases:
- i_exp=3, i_mant=0x020000 (lzc=6) -> o_exp=0, o_fract=0x080000, o_is_subnormal=1.
- i_mant=0 -> o_zero=1.
REQ-037 Overflow case: i_exp=254, i_mant=0x1000000 -> o_overflow=1, o_exp=255, o_fract=0.
REQ-038 Back-pressure: stream 4 inputs with i_valid=1 and hold i_ready=0 for 3 cycles -> o_ready=0 after 2 accepts; all 4 results emerge in order after i_ready=1, with none lost or duplicated.
REQ-039 Mid-stream reset: pulse i_rst_n=0 with both stages full -> o_valid=0 at once; no stale output appears after release.

Source files
------------

// File: rtl/mantissa_normalize_unit.sv
// Two-stage mantissa normalizer: S1 captures the raw sum plus its leading-zero count,
// S2 shifts, adjusts the exponent and classifies the result (zero/subnormal/overflow).
module mantissa_normalize_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_sign,
    input  logic [7:0]  i_exp,
    input  logic [24:0] i_mant,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_sign,
    output logic [7:0]  o_exp,
    output logic [22:0] o_fract,
    output logic        o_is_subnormal,
    output logic        o_zero,
    output logic        o_overflow
);

    logic        s1_valid;
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [24:0] s1_mant;
    logic [4:0]  s1_lzc;
    logic        s1_advance;
    logic [4:0]  lzc;

    logic [8:0]  exp9;
    logic [8:0]  exp_inc;
    logic [23:0] shl;
    logic [4:0]  sh_amt;
    logic [7:0]  n_exp;
    logic [22:0] n_fract;
    logic        n_sub;
    logic        n_zero;
    logic        n_ovf;

    assign s1_advance = !o_valid || i_ready;
    assign o_ready    = !s1_valid || s1_advance;

    // Highest set bit wins; an all-zero field is caught by the zero / carry checks in S2.
    always_comb begin
        lzc = 5'd23;
        for (int i = 0; i < 24; i++) begin
            if (i_mant[i]) lzc = 5'(23 - i);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= 8'd0;
            s1_mant  <= 25'd0;
            s1_lzc   <= 5'd0;
        end else if (o_ready) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_sign <= i_sign;
                s1_exp  <= i_exp;
                s1_mant <= i_mant;
                s1_lzc  <= lzc;
            end
        end
    end

    // Exponent math is held in 9 bits so the carry increment can never wrap.
    always_comb begin
        exp9    = {1'b0, s1_exp};
        exp_inc = exp9 + 9'd1;
        shl     = 24'd0;
        sh_amt  = 5'd0;
        n_exp   = 8'd0;
        n_fract = 23'd0;
        n_sub   = 1'b0;
        n_zero  = 1'b0;
        n_ovf   = 1'b0;
        if (s1_mant == 25'd0) begin
            n_zero = 1'b1;
        end else if (s1_mant[24]) begin
            if (exp_inc >= 9'd255) begin
                n_ovf = 1'b1;
                n_exp = 8'hff;
            end else begin
                n_exp   = exp_inc[7:0];
                n_fract = s1_mant[23:1];
            end
        end else if (exp9 > {4'd0, s1_lzc}) begin
            shl     = s1_mant[23:0] << s1_lzc;
            n_exp   = 8'(exp9 - {4'd0, s1_lzc});
            n_fract = shl[22:0];
        end else begin
            // Denormalize: shift only as far as exponent 1 allows, then report exp 0.
            sh_amt  = (s1_exp == 8'd0) ? 5'd0 : 5'(s1_exp - 8'd1);
            shl     = s1_mant[23:0] << sh_amt;
            n_fract = shl[22:0];
            n_sub   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid        <= 1'b0;
            o_sign         <= 1'b0;
            o_exp          <= 8'd0;
            o_fract        <= 23'd0;
            o_is_subnormal <= 1'b0;
            o_zero         <= 1'b0;
            o_overflow     <= 1'b0;
        end else if (s1_advance) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_sign         <= s1_sign;
                o_exp          <= n_exp;
                o_fract        <= n_fract;
                o_is_subnormal <= n_sub;
                o_zero         <= n_zero;
                o_overflow     <= n_ovf;
            end
        end
    end

endmodule
